// File: rtl/conv_pkg.sv
// Shared types and constants for the conversion-datapath sequencer.
package conv_pkg;

  localparam int unsigned ID_W       = 1;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned STAT_CNT_W = 16;
  localparam int unsigned STAT_ERR_W = 8;

  localparam logic OP_KM = 1'b1;
  localparam logic OP_MI = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ZERO   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Requester id to its one-hot response lane.
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester named by ptr wins when both are valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid[ptr]) begin
        grant[ptr] = 1'b1;
      end else if (valid[~ptr]) begin
        grant[~ptr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Arbitrates two requesters onto the metres conversion datapath, supervises it with a timeout.
// Optional build macro CONV_SCHED_STATS_EN adds per-requester response and timeout counters.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_m,
  input  logic [1:0]            req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  cv_start,
  output logic [DATA_W-1:0]     cv_m,
  output logic                  cv_op,
  input  logic                  cv_done,
  input  logic [DATA_W-1:0]     cv_result,
  output logic                  busy
`ifdef CONV_SCHED_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] stat_cnt0,
  output logic [STAT_CNT_W-1:0] stat_cnt1,
  output logic [STAT_ERR_W-1:0] stat_err
`endif
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic                op_q, op_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  logic [1:0]          grant;
  logic                hs;
  logic [ID_W-1:0]     g_id;
  logic [DATA_W-1:0]   m_sel;
  logic                rsp_fire;
  logic                tmo_fire;

  rr_arb2 u_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE),
    .grant (grant)
  );

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign g_id      = grant[1];
  assign m_sel     = g_id ? req_m[2*DATA_W-1:DATA_W] : req_m[DATA_W-1:0];
  assign rsp_fire  = (state_q == ST_RESP) && rsp_ready[id_q];
  assign tmo_fire  = (state_q == ST_WAIT) && !cv_done && (tmr_q == TMR_LAST);

  // Next-state and datapath latches
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    m_d     = m_q;
    op_d    = op_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          id_d    = g_id;
          m_d     = m_sel;
          op_d    = req_op[g_id];
          ptr_d   = ~g_id;
          state_d = (m_sel == '0) ? ST_ZERO : ST_LAUNCH;
        end
      end
      ST_ZERO: begin
        data_d  = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_LAUNCH: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the final timer cycle still counts as success.
        if (cv_done) begin
          data_d  = cv_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (tmo_fire) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmr_d = TMR_W'(tmr_q + 1'b1);
        end
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      tmr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      m_q     <= m_d;
      op_q    <= op_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign cv_start  = (state_q == ST_LAUNCH);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP) ? id_onehot(id_q) : 2'b00;
  assign cv_m      = m_q;
  assign cv_op     = op_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

`ifdef CONV_SCHED_STATS_EN
  logic [STAT_CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [STAT_ERR_W-1:0] errc_q, errc_d;

  // Saturating activity counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    errc_d = errc_q;
    if (rsp_fire && (id_q == 1'b0) && (cnt0_q != '1)) begin
      cnt0_d = STAT_CNT_W'(cnt0_q + 1'b1);
    end
    if (rsp_fire && (id_q == 1'b1) && (cnt1_q != '1)) begin
      cnt1_d = STAT_CNT_W'(cnt1_q + 1'b1);
    end
    if (tmo_fire && (errc_q != '1)) begin
      errc_d = STAT_ERR_W'(errc_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      errc_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      errc_q <= errc_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
  assign stat_err  = errc_q;
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched with a behavioural datapath and response model.
module tb_conv_sched;
  import conv_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_m;
  logic [1:0]      req_op;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            cv_start;
  logic [DW-1:0]   cv_m;
  logic            cv_op;
  logic            cv_done;
  logic [DW-1:0]   cv_result;
  logic            busy;
`ifdef CONV_SCHED_STATS_EN
  logic [15:0]     stat_cnt0;
  logic [15:0]     stat_cnt1;
  logic [7:0]      stat_err;
`endif

  conv_sched #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m     (req_m),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .cv_start  (cv_start),
    .cv_m      (cv_m),
    .cv_op     (cv_op),
    .cv_done   (cv_done),
    .cv_result (cv_result),
    .busy      (busy)
`ifdef CONV_SCHED_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  bit exp_fav;
  int dp_lat;
  int stray_req;
  int resp_cnt0, resp_cnt1, tmo_cnt;

  function automatic logic [1:0] oh(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  // Datapath behaviour: unit conversion with the operand's top byte folded in to exercise full width.
  function automatic logic [DW-1:0] dp_func(input logic [DW-1:0] m, input logic op);
    logic [DW-1:0] q;
    q = (op == OP_KM) ? m / 1000 : m / 1609;
    if (m < 32'h0100_0000) return q;
    return q | {m[DW-1:DW-8], 24'h0};
  endfunction

  // Datapath model: answers dp_lat cycles after the cv_start cycle; 0 means never.
  initial begin : dp_model
    int seen;
    logic [DW-1:0] lm;
    logic lo;
    int lat;
    bit abort;
    seen = 0;
    cv_done = 1'b0;
    cv_result = '0;
    forever begin
      @(negedge clk);
      if (stray_req != seen) begin
        seen = stray_req;
        cv_done = 1'b1;
        cv_result = 32'hDEAD_BEEF;
        @(negedge clk);
        cv_done = 1'b0;
      end else if (cv_start === 1'b1 && rst === 1'b1 && dp_lat > 0) begin
        lm = cv_m;
        lo = cv_op;
        lat = dp_lat;
        abort = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) abort = 1'b1;
        end
        if (!abort) begin
          cv_done = 1'b1;
          cv_result = dp_func(lm, lo);
          @(negedge clk);
          cv_done = 1'b0;
        end
      end
    end
  end

  // One full transaction from requester r, with expected outcome derived from the rules.
  task automatic do_txn(input int r, input logic [DW-1:0] m, input logic op, input int lat, input int hold);
    logic [DW-1:0] exp_data;
    logic exp_err;
    int exp_lat, acc, got, starts, first_start;
    bit launches;
    launches = (m != '0);
    if (!launches) begin
      exp_data = '0; exp_err = 1'b0; exp_lat = 2;
    end else if (lat >= 1 && lat <= TO) begin
      exp_data = dp_func(m, op); exp_err = 1'b0; exp_lat = lat + 2;
    end else begin
      exp_data = '0; exp_err = 1'b1; exp_lat = TO + 2;
    end
    dp_lat = lat;
    @(negedge clk);
    req_m[r*DW +: DW] = m;
    req_op[r] = op;
    req_valid[r] = 1'b1;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      #1;
      if (req_ready[r] === 1'b1) acc = cyc;
      else @(negedge clk);
    end
    compared++;
    if (acc < 0) begin
      mismatched++;
      $display("FAIL txn_accept r=%0d: req_ready=%b never granted", r, req_ready);
      req_valid = 2'b00;
      return;
    end
    compared++;
    if (req_ready !== oh(r)) begin
      mismatched++;
      $display("FAIL txn_ready_onehot r=%0d: got %b expected %b", r, req_ready, oh(r));
    end
    exp_fav = (r == 0);
    @(negedge clk);
    req_valid[r] = 1'b0;
    got = -1; starts = 0; first_start = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      #1;
      if (cv_start === 1'b1) begin
        starts++;
        if (first_start < 0) begin
          first_start = cyc;
          compared++;
          if (cv_m !== m || cv_op !== op) begin
            mismatched++;
            $display("FAIL cv_operand: got m=%h op=%b expected m=%h op=%b", cv_m, cv_op, m, op);
          end
        end
      end
      if (rsp_valid !== 2'b00) got = cyc;
      else @(negedge clk);
    end
    compared++;
    if (got < 0) begin
      mismatched++;
      $display("FAIL txn_rsp_timeout r=%0d: no rsp_valid within budget", r);
      return;
    end
    compared++;
    if (got - acc != exp_lat) begin
      mismatched++;
      $display("FAIL txn_latency r=%0d: got %0d expected %0d", r, got - acc, exp_lat);
    end
    compared++;
    if (starts != (launches ? 1 : 0)) begin
      mismatched++;
      $display("FAIL cv_start_count r=%0d: got %0d expected %0d", r, starts, launches ? 1 : 0);
    end
    if (launches) begin
      compared++;
      if (first_start - acc != 1) begin
        mismatched++;
        $display("FAIL cv_start_time: got %0d expected 1", first_start - acc);
      end
    end
    compared++;
    if (rsp_valid !== oh(r) || rsp_data !== exp_data || rsp_err !== exp_err) begin
      mismatched++;
      $display("FAIL txn_rsp r=%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
               r, rsp_valid, rsp_data, rsp_err, oh(r), exp_data, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rsp_ready = oh(1 - r);
      req_valid = 2'b11;
      #1;
      compared++;
      if (rsp_valid !== oh(r) || rsp_data !== exp_data || rsp_err !== exp_err || req_ready !== 2'b00) begin
        mismatched++;
        $display("FAIL rsp_hold h=%0d: got v=%b d=%h e=%b rdy=%b expected v=%b d=%h e=%b rdy=00",
                 h, rsp_valid, rsp_data, rsp_err, req_ready, oh(r), exp_data, exp_err);
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = oh(r);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    compared++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rsp_release: got v=%b busy=%b expected v=00 busy=0", rsp_valid, busy);
    end
    if (r == 0) resp_cnt0++; else resp_cnt1++;
    if (exp_err) tmo_cnt++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || cv_start !== 1'b0 || req_ready !== 2'b00 ||
        rsp_data !== '0 || rsp_err !== 1'b0 || cv_m !== '0 || cv_op !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: busy=%b v=%b st=%b rdy=%b d=%h e=%b m=%h op=%b expected all 0",
               busy, rsp_valid, cv_start, req_ready, rsp_data, rsp_err, cv_m, cv_op);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_fav = 1'b0;
    resp_cnt0 = 0; resp_cnt1 = 0; tmo_cnt = 0;
    #1;
    req_valid = 2'b11;
    #1;
    compared++;
    if (req_ready !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_favour: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_basic;
    do_txn(0, 32'd5000, OP_KM, 3, 0);
    compared++;
    if (dp_func(32'd5000, OP_KM) !== rsp_data && rsp_data !== 32'd5) begin
      mismatched++;
      $display("FAIL basic_km_value: got %h expected 5", rsp_data);
    end
  endtask

  task automatic test_zero;
    do_txn(1, 32'd0, OP_MI, 3, 0);
  endtask

  task automatic test_timeout;
    do_txn(0, 32'd12345, OP_MI, 0, 0);
    do_txn(1, 32'hA000_1234, OP_KM, TO, 0);
    do_txn(0, 32'd777777, OP_KM, TO + 1, 1);
  endtask

  task automatic test_resp_hold;
    do_txn(1, $urandom | 32'h1, OP_MI, 2, 10);
  endtask

  task automatic test_stray;
    @(negedge clk);
    stray_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      compared++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
        mismatched++;
        $display("FAIL stray_done i=%0d: busy=%b v=%b expected 0/00", i, busy, rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] mm [2];
    logic oo [2];
    int n [2];
    int q[$];
    int nresp, id;
    logic [1:0] g;
    mm[0] = $urandom | 32'h1; mm[1] = $urandom | 32'h1;
    oo[0] = 1'($urandom); oo[1] = 1'($urandom);
    n[0] = 0; n[1] = 0; nresp = 0;
    dp_lat = 2;
    @(negedge clk);
    req_m = {mm[1], mm[0]};
    req_op = {oo[1], oo[0]};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 400 && nresp < 8; i++) begin
      #1;
      g = req_valid & req_ready;
      if (g != 2'b00) begin
        compared++;
        if (g !== oh(exp_fav ? 1 : 0)) begin
          mismatched++;
          $display("FAIL b2b_grant: got %b expected %b", g, oh(exp_fav ? 1 : 0));
        end
        id = g[1] ? 1 : 0;
        q.push_back(id);
        n[id]++;
        exp_fav = (id == 0);
      end
      if (rsp_valid != 2'b00) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL b2b_unexpected_rsp: got v=%b expected none", rsp_valid);
        end else begin
          id = q.pop_front();
          if (rsp_valid !== oh(id) || rsp_data !== dp_func(mm[id], oo[id]) || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=0",
                     rsp_valid, rsp_data, rsp_err, oh(id), dp_func(mm[id], oo[id]));
          end
          if (id == 0) resp_cnt0++; else resp_cnt1++;
        end
        nresp++;
      end
      @(negedge clk);
      if (n[0] >= 4) req_valid[0] = 1'b0;
      if (n[1] >= 4) req_valid[1] = 1'b0;
    end
    compared++;
    if (nresp != 8 || n[0] != 4 || n[1] != 4) begin
      mismatched++;
      $display("FAIL b2b_count: got rsp=%0d n0=%0d n1=%0d expected 8/4/4", nresp, n[0], n[1]);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid;
    bit seen;
    dp_lat = 0;
    seen = 1'b0;
    @(negedge clk);
    req_m[DW-1:0] = 32'h0001_0000;
    req_op[0] = OP_KM;
    req_valid = 2'b01;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (cv_start === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    req_valid = 2'b00;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL rstmid_launch: cv_start never seen");
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || cv_start !== 1'b0 || req_ready !== 2'b00 ||
        cv_m !== '0 || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_outputs: busy=%b v=%b st=%b rdy=%b m=%h e=%b expected all 0",
               busy, rsp_valid, cv_start, req_ready, cv_m, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_fav = 1'b0;
    resp_cnt0 = 0; resp_cnt1 = 0; tmo_cnt = 0;
    #1;
    req_valid = 2'b11;
    #1;
    compared++;
    if (req_ready !== 2'b01) begin
      mismatched++;
      $display("FAIL rstmid_favour: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
    do_txn(0, 32'd2500000, OP_KM, 4, 1);
  endtask

  task automatic test_random;
    int r, sel, lat, hold;
    logic [DW-1:0] m;
    logic op;
    for (int t = 0; t < 16; t++) begin
      r = int'($urandom_range(0, 1));
      m = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      op = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) lat = 0;
      else if (sel == 1) lat = TO;
      else if (sel == 2) lat = TO + 1;
      else lat = int'($urandom_range(1, TO - 1));
      hold = int'($urandom_range(0, 3));
      do_txn(r, m, op, lat, hold);
    end
  endtask

  task automatic test_stats;
`ifdef CONV_SCHED_STATS_EN
    #1;
    compared++;
    if (stat_cnt0 !== 16'(resp_cnt0) || stat_cnt1 !== 16'(resp_cnt1) || stat_err !== 8'(tmo_cnt)) begin
      mismatched++;
      $display("FAIL stats: got c0=%0d c1=%0d e=%0d expected c0=%0d c1=%0d e=%0d",
               stat_cnt0, stat_cnt1, stat_err, resp_cnt0, resp_cnt1, tmo_cnt);
    end
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 1'b0;
    req_valid = 2'b00;
    req_m = '0;
    req_op = 2'b00;
    rsp_ready = 2'b00;
    dp_lat = 0;
    stray_req = 0;
    exp_fav = 1'b0;
    resp_cnt0 = 0; resp_cnt1 = 0; tmo_cnt = 0;
    test_reset();
    test_basic();
    test_zero();
    test_timeout();
    test_resp_hold();
    test_stray();
    test_back_to_back();
    test_random();
    test_stats();
    test_reset_mid();
    test_stats();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
